// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer: command nibbles, state
// encoding and the command decoder.
package spi_cmd_sequencer_pkg;

    localparam int ADDR_W_DEF = 24;

    localparam logic [3:0] CMD_SET_ADDR = 4'h1;
    localparam logic [3:0] CMD_READ     = 4'h8;
    localparam logic [3:0] CMD_WRITE    = 4'h9;
    localparam logic [3:0] CMD_STATUS   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_RD     = 3'd2,
        ST_WR     = 3'd3,
        ST_IGNORE = 3'd4,
        ST_STATUS = 3'd5
    } state_e;

    function automatic state_e decode_cmd(input logic [3:0] nib);
        case (nib)
            CMD_SET_ADDR: return ST_ADDR;
            CMD_READ:     return ST_RD;
            CMD_WRITE:    return ST_WR;
            CMD_STATUS:   return ST_STATUS;
            default:      return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_mem_port.sv
// Memory request engine: latches one access on issue, holds it stable on the
// shared port until mem_ack, then frees the port for the next issue.
module spi_mem_port #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [7:0]        issue_wdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done
);

    assign busy = mem_req;
    // An ack with no request outstanding is ignored.
    assign done = mem_req & mem_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (mem_req) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
            end
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= issue_we;
            mem_addr  <= issue_addr;
            mem_wdata <= issue_wdata;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Turns SPI command/parameter byte strobes into auto-incrementing memory
// accesses and selects the byte returned to the MCU on MISO.
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_ready,
    input  logic              param_ready,
    input  logic [7:0]        cmd_data,
    input  logic [7:0]        param_data,
    input  logic              startmessage,
    input  logic              endmessage,
    output logic [7:0]        spi_tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              overrun
);

    localparam int EXT_W = (ADDR_W > 24) ? ADDR_W : 24;

    state_e            state;
    state_e            dec;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic              rd_pending;
    logic              busy;
    logic              done;
    logic              evt_msg;
    logic              cmd_go;
    logic              par_go;
    logic              rd_req;
    logic              wr_req;
    logic              issue;
    logic              unused_cmd_low;

    assign unused_cmd_low = ^cmd_data[3:0];

    function automatic logic [ADDR_W-1:0] load_addr_byte(input logic [ADDR_W-1:0] a,
                                                         input logic [1:0]        idx,
                                                         input logic [7:0]        b);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(a);
        case (idx)
            2'd0:    ext[23:16] = b;
            2'd1:    ext[15:8]  = b;
            default: ext[7:0]   = b;
        endcase
        return ext[ADDR_W-1:0];
    endfunction

    function automatic logic [7:0] status_byte(input state_e s);
        return {overrun, mem_req, 3'b000, s};
    endfunction

    assign dec     = decode_cmd(cmd_data[7:4]);
    assign evt_msg = startmessage | endmessage;
    assign cmd_go  = cmd_ready & ~evt_msg;
    assign par_go  = param_ready & ~evt_msg & ~cmd_ready;

    // Reads go out the same cycle RD is entered when the port is free.
    assign rd_req = ~evt_msg & ((cmd_go & (dec == ST_RD)) |
                                (~cmd_ready & (state == ST_RD) & rd_pending));
    assign wr_req = par_go & (state == ST_WR);
    assign issue  = (rd_req | wr_req) & ~busy;

    spi_mem_port #(
        .ADDR_W (ADDR_W)
    ) u_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .issue_we    (wr_req),
        .issue_addr  (addr),
        .issue_wdata (param_data),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            byte_cnt    <= 2'd0;
            rd_pending  <= 1'b0;
            overrun     <= 1'b0;
            spi_tx_data <= 8'h00;
        end else begin
            // Completions land even after the message that issued them ended.
            if (done) begin
                addr <= addr + ADDR_W'(1);
                if (!mem_we) begin
                    spi_tx_data <= mem_rdata;
                end
            end

            if (evt_msg) begin
                state      <= ST_IDLE;
                rd_pending <= 1'b0;
                if (startmessage) begin
                    overrun <= 1'b0;
                end
            end else if (cmd_ready) begin
                state      <= dec;
                byte_cnt   <= 2'd0;
                rd_pending <= (dec == ST_RD) & busy;
                if (dec == ST_IGNORE) begin
                    spi_tx_data <= FILL_BYTE;
                end else if (dec == ST_STATUS) begin
                    spi_tx_data <= status_byte(ST_STATUS);
                end
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (par_go && byte_cnt != 2'd3) begin
                            addr     <= load_addr_byte(addr, byte_cnt, param_data);
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    ST_WR: begin
                        if (par_go && busy) begin
                            overrun <= 1'b1;
                        end
                    end
                    ST_RD: begin
                        if (issue) begin
                            rd_pending <= 1'b0;
                        end
                        if (par_go) begin
                            if (busy || rd_pending) begin
                                overrun <= 1'b1;
                            end else begin
                                rd_pending <= 1'b1;
                            end
                        end
                    end
                    ST_STATUS: begin
                        spi_tx_data <= status_byte(state);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: hand-computed expectations checked
// with immediate assertions after each step.
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_ready;
    logic        param_ready;
    logic [7:0]  cmd_data;
    logic [7:0]  param_data;
    logic        startmessage;
    logic        endmessage;
    logic [7:0]  spi_tx_data;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_cmd_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_ready    (cmd_ready),
        .param_ready  (param_ready),
        .cmd_data     (cmd_data),
        .param_data   (param_data),
        .startmessage (startmessage),
        .endmessage   (endmessage),
        .spi_tx_data  (spi_tx_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .overrun      (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd_data = c; cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    task automatic send_param(input logic [7:0] p);
        param_data = p; param_ready = 1'b1;
        step();
        param_ready = 1'b0;
    endtask

    task automatic send_start();
        startmessage = 1'b1;
        step();
        startmessage = 1'b0;
    endtask

    task automatic send_end();
        endmessage = 1'b1;
        step();
        endmessage = 1'b0;
    endtask

    task automatic send_ack(input logic [7:0] rd);
        mem_rdata = rd; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
        send_start();
        send_cmd(8'h10);
        send_param(a2);
        send_param(a1);
        send_param(a0);
        send_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_ready = 1'b0; param_ready = 1'b0;
        cmd_data = 8'h00; param_data = 8'h00;
        startmessage = 1'b0; endmessage = 1'b0;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        steps(2);
        rst_n = 1'b1;

        check("rst_tx",      32'(spi_tx_data), 32'h00);
        check("rst_req",     32'(mem_req),     32'h0);
        check("rst_addr",    32'(mem_addr),    32'h000000);
        check("rst_wdata",   32'(mem_wdata),   32'h00);
        check("rst_we",      32'(mem_we),      32'h0);
        check("rst_overrun", 32'(overrun),     32'h0);

        // SET_ADDR then WRITE
        set_addr(8'h12, 8'h34, 8'h56);
        send_start();
        send_cmd(8'h90);
        send_param(8'hAA);
        check("wr_req",   32'(mem_req),   32'h1);
        check("wr_addr",  32'(mem_addr),  32'h123456);
        check("wr_wdata", 32'(mem_wdata), 32'hAA);
        check("wr_we",    32'(mem_we),    32'h1);
        steps(2);
        send_ack(8'h00);
        check("wr_req_drop", 32'(mem_req), 32'h0);
        send_end();

        // READ stream with prefetch and dummy byte
        set_addr(8'h00, 8'h01, 8'h00);
        send_start();
        send_cmd(8'h80);
        check("rd_req",  32'(mem_req),  32'h1);
        check("rd_we",   32'(mem_we),   32'h0);
        check("rd_addr", 32'(mem_addr), 32'h000100);
        steps(2);
        send_ack(8'h5C);
        check("rd_tx",       32'(spi_tx_data), 32'h5C);
        check("rd_req_drop", 32'(mem_req),     32'h0);
        send_param(8'hFF);
        check("rd_no_req_yet", 32'(mem_req), 32'h0);
        step();
        check("rd2_req",  32'(mem_req),  32'h1);
        check("rd2_addr", 32'(mem_addr), 32'h000101);
        send_ack(8'h77);
        check("rd2_tx", 32'(spi_tx_data), 32'h77);
        send_end();

        // Overrun during a long write, observed through STATUS
        set_addr(8'h00, 8'h20, 8'h00);
        send_start();
        send_cmd(8'h90);
        send_param(8'h11);
        check("ovr_req_addr", 32'(mem_addr), 32'h002000);
        steps(5);
        send_param(8'h22);
        check("ovr_set",        32'(overrun),   32'h1);
        check("ovr_wdata_hold", 32'(mem_wdata), 32'h11);
        send_cmd(8'hF0);
        check("status_busy", 32'(spi_tx_data), 32'hC5);
        steps(12);
        send_ack(8'h00);
        step();
        check("status_idle", 32'(spi_tx_data), 32'h85);
        send_end();
        check("ovr_sticky", 32'(overrun), 32'h1);
        send_start();
        check("ovr_clear", 32'(overrun), 32'h0);
        send_end();

        // Address wrap
        set_addr(8'hFF, 8'hFF, 8'hFF);
        send_start();
        send_cmd(8'h90);
        send_param(8'h01);
        check("wrap_addr0", 32'(mem_addr), 32'hFFFFFF);
        send_ack(8'h00);
        send_param(8'h02);
        check("wrap_addr1",  32'(mem_addr),  32'h000000);
        check("wrap_wdata1", 32'(mem_wdata), 32'h02);
        send_ack(8'h00);
        send_end();

        // Abort with a read outstanding (addr is now 0x000001)
        send_start();
        send_cmd(8'h80);
        check("abort_addr", 32'(mem_addr), 32'h000001);
        send_end();
        check("abort_req_held", 32'(mem_req),   32'h1);
        check("abort_idle",     32'(dut.state), 32'h0);
        steps(2);
        check("abort_req_still", 32'(mem_req),  32'h1);
        check("abort_addr_hold", 32'(mem_addr), 32'h000001);
        send_ack(8'h3C);
        check("abort_tx", 32'(spi_tx_data), 32'h3C);
        steps(3);
        check("abort_no_more", 32'(mem_req), 32'h0);

        // Reset in the middle of a request, then unknown command
        send_start();
        send_cmd(8'h90);
        send_param(8'h55);
        check("pre_rst_req", 32'(mem_req), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_req",   32'(mem_req),     32'h0);
        check("mid_rst_addr",  32'(mem_addr),    32'h000000);
        check("mid_rst_wdata", 32'(mem_wdata),   32'h00);
        check("mid_rst_we",    32'(mem_we),      32'h0);
        check("mid_rst_tx",    32'(spi_tx_data), 32'h00);
        check("mid_rst_state", 32'(dut.state),   32'h0);
        send_cmd(8'h35);
        check("ignore_fill", 32'(spi_tx_data), 32'hFF);
        send_param(8'h99);
        check("ignore_no_req", 32'(mem_req), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command sequencer behind the SPI slave: consumes the byte-level cmd/param strobes and turns MCU messages into 24-bit-address memory accesses with auto-increment. It owns the shared memory request port (req/ack handshake) and drives the byte the SPI slave shifts out on MISO. Sits between the SPI slave and the memory arbiter in the FPGA top level.

## Interface
- ADDR_W, 24, memory address width
- FILL_BYTE, 8'hFF, tx byte for unknown commands
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_ready  in  1  one-cycle pulse: cmd_data valid (first byte of message)
- param_ready  in  1  one-cycle pulse: param_data valid (subsequent bytes)
- cmd_data  in  8  command byte
- param_data  in  8  parameter byte
- startmessage  in  1  one-cycle pulse, SSEL falling
- endmessage  in  1  one-cycle pulse, SSEL rising
- spi_tx_data  out  8  byte presented to the SPI slave for shifting out
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  8  write data
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_req  out  1  request, held until mem_ack
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid same cycle
- mem_rdata  in  8  read data
- overrun  out  1  sticky: param byte dropped because port was busy

## Operation
- Command decode on cmd_data[7:4]: 0x1 SET_ADDR, 0x8 READ_STREAM, 0x9 WRITE_STREAM, 0xF STATUS; anything else IGNORE.
- FSM states: IDLE, ADDR, RD, WR, IGNORE. cmd_ready moves IDLE/any → state from decode. endmessage or startmessage → IDLE.
- ADDR: param bytes 1..3 load addr[23:16], [15:8], [7:0] (MSB first) immediately per byte; bytes ≥4 ignored. Short message leaves remaining addr bits unchanged.
- WR: each param_ready with port idle issues write (addr, param_data); addr increments at ack.
- RD: entering RD sets rd_pending; read issued as soon as port idle. At ack, spi_tx_data ← mem_rdata, addr increments. Each param_ready in RD (dummy byte clocked by MCU) sets rd_pending for the next prefetch.
- STATUS: spi_tx_data ← {overrun, mem_req, 3'b0, state[2:0]} on entry, refreshed every cycle while in STATUS.
- IGNORE: spi_tx_data ← FILL_BYTE; params discarded.
- Port busy (mem_req high or pending issue) when param_ready arrives in WR/RD: byte dropped, overrun ← 1. overrun cleared only by startmessage or reset.
- addr arithmetic modulo 2^ADDR_W: 0xFFFFFF + 1 → 0x000000.
- Message abort: endmessage with mem_req high keeps request asserted until ack; addr/tx updates at that ack still occur; rd_pending cleared on endmessage.
- Reset: state IDLE, addr 0, spi_tx_data 0, mem_req 0, mem_we 0, mem_wdata 0, mem_addr 0, overrun 0, rd_pending 0.

## Timing
- cmd_ready at cycle t → new state at t+1.
- WR: param_ready at t → mem_req=1, mem_we=1, mem_addr/mem_wdata stable at t+1.
- RD: cmd_ready at t (port idle) → mem_req=1, mem_we=0 at t+1.
- mem_ack at k → mem_req=0 at k+1; addr+1 and spi_tx_data update at k+1; new request earliest k+2.
- mem_addr/mem_wdata/mem_we never change while mem_req high.
- Priority in one cycle: reset > startmessage/endmessage > cmd_ready > param_ready. mem_ack always processed regardless of other inputs.

## Structure
- Shared package: command nibble constants (CMD_SET_ADDR, CMD_READ, CMD_WRITE, CMD_STATUS), state enum encoding, ADDR_W default.
- One sub-module: spi_mem_port — req/ack handshake engine holding addr/wdata/we stable, issue when idle, busy output, ack pass-through; FSM and addr counter stay in the top.

## Test plan
- SET_ADDR 0x10, params 0x12 0x34 0x56 → internal addr 0x123456; following WRITE 0x90, 0xAA → mem_req with addr 0x123456, wdata 0xAA, we=1.
- READ 0x80 at addr 0x000100, ack with rdata 0x5C after 3 cycles → spi_tx_data=0x5C one cycle after ack, next request addr 0x000101 after dummy param.
- WRITE stream with ack delayed 20 cycles, second param arrives mid-request → byte dropped, overrun=1, status read (0xF0) returns bit7=1; next startmessage clears it.
- Address wrap: addr 0xFFFFFF, write 0x01 → after ack addr 0x000000.
- endmessage while mem_req high → req held until ack, state IDLE, no further requests.
- rst_n low mid-request for 1 cycle → all outputs 0 next cycle, state IDLE; unknown cmd 0x3x afterwards → spi_tx_data=0xFF.
